// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rising-to-rising period of an asynchronous PWM
// input in prescaler units, publishing each completed period with a one-cycle strobe.
//
// state | meaning
// IDLE  | no reference rise yet (after reset or timeout); counters held at 0
// HIGH  | input high inside a measured period
// LOW   | input low, waiting for the rise that closes the period
module pwm_capture #(
  parameter int R          = 8,
  parameter int TIMER_BITS = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TIMER_BITS-1:0] FINAL_VALUE,
  input  logic                  pwm_in,
  output logic [R+1:0]          duty_out,
  output logic [R+1:0]          period_out,
  output logic                  valid,
  output logic                  timeout
);

  localparam int W = R + 2;
  localparam logic [W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync2_q, dly_q;
  logic                  rise, fall, tick;
  logic [TIMER_BITS-1:0] pre_q, pre_d, pre_cur;
  logic [W-1:0]          hi_q, hi_d, per_q, per_d;
  logic [W-1:0]          duty_q, duty_d, period_q, period_d;
  logic [W-1:0]          start_val, hi_inc, per_inc;
  logic                  valid_q, valid_d, to_q, to_d;

  assign rise = sync2_q & ~dly_q;
  assign fall = ~sync2_q & dly_q;

  // The rise cycle is clock 0 of the new period, so the prescaler phase restarts there.
  // Using >= lets a lowered FINAL_VALUE wrap at once instead of running to 2^TIMER_BITS.
  always_comb begin
    pre_cur = rise ? '0 : pre_q;
    tick    = (pre_cur >= FINAL_VALUE);
    pre_d   = tick ? '0 : pre_cur + 1'b1;
  end

  // A tick in the rise cycle already belongs to the new period.
  assign start_val = {{(W-1){1'b0}}, tick};
  assign hi_inc    = (hi_q == CNT_MAX)  ? hi_q  : hi_q + 1'b1;
  assign per_inc   = (per_q == CNT_MAX) ? per_q : per_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    per_d    = per_q;
    duty_d   = duty_q;
    period_d = period_q;
    valid_d  = 1'b0;
    to_d     = to_q;
    case (state_q)
      IDLE: begin
        hi_d  = '0;
        per_d = '0;
        if (rise) begin
          hi_d    = start_val;
          per_d   = start_val;
          to_d    = 1'b0;
          state_d = HIGH;
        end
      end
      HIGH, LOW: begin
        if (rise) begin
          duty_d   = hi_q;
          period_d = per_q;
          valid_d  = 1'b1;
          hi_d     = start_val;
          per_d    = start_val;
          state_d  = HIGH;
        end else begin
          if (tick) per_d = per_inc;
          // The fall cycle is the first low clock, so its tick counts toward the period only.
          if (tick && state_q == HIGH && !fall) hi_d = hi_inc;
          if (state_q == HIGH && fall) state_d = LOW;
          if (per_d == CNT_MAX) begin
            to_d    = 1'b1;
            hi_d    = '0;
            per_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        hi_d    = '0;
        per_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      dly_q    <= 1'b0;
      pre_q    <= '0;
      state_q  <= IDLE;
      hi_q     <= '0;
      per_q    <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      sync1_q  <= pwm_in;
      sync2_q  <= sync1_q;
      dly_q    <= sync2_q;
      pre_q    <= pre_d;
      state_q  <= state_d;
      hi_q     <= hi_d;
      per_q    <= per_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      to_q     <= to_d;
    end
  end

  assign duty_out   = duty_q;
  assign period_out = period_q;
  assign valid      = valid_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scenario tasks plus a cycle-accurate edge-timestamp reference model
// for pwm_capture (R=8, TIMER_BITS=15).
module tb_pwm_capture;
  localparam int R    = 8;
  localparam int TB   = 15;
  localparam int W    = R + 2;
  localparam int MAXC = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset, pwm_in;
  logic [TB-1:0] fv;
  logic [W-1:0]  duty_out, period_out;
  logic          valid, timeout;

  pwm_capture #(.R(R), .TIMER_BITS(TB)) dut (
    .clk(clk), .reset(reset), .FINAL_VALUE(fv), .pwm_in(pwm_in),
    .duty_out(duty_out), .period_out(period_out), .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit live  = 0;

  typedef struct {int cyc; int duty; int per;} obs_t;
  obs_t obs_q[$];
  int   to_rise_cyc = -1;
  bit   prev_to = 0;

  // Reference model: input seen through a two-sample synchronizer; measurements are
  // edge-timestamp differences divided by the unit length.
  bit h1, h2, h3, armed, m_valid, m_to, rise_e, fall_e;
  int last_rise, last_fall, m_duty, m_per, unit;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset === 1'b1) begin
        live = 1; h1 = 0; h2 = 0; h3 = 0; armed = 0;
        m_valid = 0; m_to = 0; m_duty = 0; m_per = 0;
      end else begin
        rise_e  = h2 & ~h3;
        fall_e  = ~h2 & h3;
        unit    = int'(fv) + 1;
        m_valid = 0;
        if (rise_e) begin
          if (armed) begin
            m_duty  = (last_fall - last_rise) / unit;
            m_per   = (cyc - 1 - last_rise) / unit;
            m_valid = 1;
          end
          m_to = 0; armed = 1; last_rise = cyc - 1;
        end else begin
          if (fall_e) last_fall = cyc - 1;
          if (armed && (cyc - last_rise) == MAXC * unit) begin
            m_to = 1; armed = 0;
          end
        end
        h3 = h2; h2 = h1; h1 = pwm_in;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        n_cmp++;
        if ({valid, timeout, duty_out, period_out} !== {m_valid, m_to, W'(m_duty), W'(m_per)}) begin
          n_bad++;
          $display("FAIL cycle_model cyc=%0d got v=%b to=%b duty=%0d per=%0d expected v=%b to=%b duty=%0d per=%0d",
                   cyc, valid, timeout, duty_out, period_out, m_valid, m_to, m_duty, m_per);
        end
        if (valid === 1'b1) obs_q.push_back('{cyc, int'(duty_out), int'(period_out)});
        if (timeout === 1'b1 && !prev_to) to_rise_cyc = cyc;
        prev_to = (timeout === 1'b1);
      end
    end
  end

  task automatic drive(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    fv = 0; pwm_in = 0;
    do_reset();
    obs_q.delete();
    n_cmp++;
    if (duty_out !== '0 || period_out !== '0) begin
      n_bad++; $display("FAIL reset_outputs got duty=%0d per=%0d expected 0/0", duty_out, period_out);
    end
    n_cmp++;
    if (valid !== 1'b0 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags got v=%b to=%b expected 0/0", valid, timeout);
    end
    drive(0, 10);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL reset_idle_valid got %0d valids expected 0", obs_q.size());
    end
  endtask

  task automatic test_basic();
    fv = 0; pwm_in = 0;
    do_reset(); obs_q.delete();
    drive(0, 4);
    repeat (4) begin drive(1, 3); drive(0, 5); end
    n_cmp++;
    if (obs_q.size() != 3) begin
      n_bad++; $display("FAIL basic_count got %0d expected 3", obs_q.size());
    end
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i].duty != 3 || obs_q[i].per != 8) begin
        n_bad++; $display("FAIL basic_value[%0d] got %0d/%0d expected 3/8", i, obs_q[i].duty, obs_q[i].per);
      end
    end
  endtask

  task automatic test_scaled();
    fv = 3; pwm_in = 0;
    do_reset(); obs_q.delete();
    drive(0, 4);
    repeat (4) begin drive(1, 40); drive(0, 60); end
    n_cmp++;
    if (obs_q.size() != 3) begin
      n_bad++; $display("FAIL scaled_count got %0d expected 3", obs_q.size());
    end
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i].duty != 10 || obs_q[i].per != 25) begin
        n_bad++; $display("FAIL scaled_value[%0d] got %0d/%0d expected 10/25", i, obs_q[i].duty, obs_q[i].per);
      end
      if (i > 0) begin
        n_cmp++;
        if (obs_q[i].cyc - obs_q[i-1].cyc != 100) begin
          n_bad++; $display("FAIL scaled_spacing[%0d] got %0d expected 100", i, obs_q[i].cyc - obs_q[i-1].cyc);
        end
      end
    end
  endtask

  task automatic test_timeout();
    fv = 0; pwm_in = 0;
    do_reset(); obs_q.delete();
    drive(0, 4);
    repeat (2) begin drive(1, 3); drive(0, 5); end
    drive(1, 1100);
    n_cmp++;
    if (timeout !== 1'b1) begin
      n_bad++; $display("FAIL timeout_set got %b expected 1", timeout);
    end
    n_cmp++;
    if (obs_q.size() != 2) begin
      n_bad++; $display("FAIL timeout_no_valid got %0d valids expected 2", obs_q.size());
    end
    // The stuck-high rise publishes one cycle after it is detected; timeout follows 1023 after detection.
    n_cmp++;
    if (obs_q.size() > 0 && to_rise_cyc - obs_q[obs_q.size()-1].cyc != 1022) begin
      n_bad++; $display("FAIL timeout_latency got %0d expected 1022", to_rise_cyc - obs_q[obs_q.size()-1].cyc);
    end
    n_cmp++;
    if (duty_out !== W'(3) || period_out !== W'(8)) begin
      n_bad++; $display("FAIL timeout_hold got %0d/%0d expected 3/8", duty_out, period_out);
    end
    drive(0, 5); drive(1, 3); drive(0, 5);
    n_cmp++;
    if (timeout !== 1'b0 || obs_q.size() != 2) begin
      n_bad++; $display("FAIL timeout_clear got to=%b valids=%0d expected 0/2", timeout, obs_q.size());
    end
    drive(1, 3); drive(0, 5);
    n_cmp++;
    if (obs_q.size() != 3 || obs_q[obs_q.size()-1].duty != 3 || obs_q[obs_q.size()-1].per != 8) begin
      n_bad++; $display("FAIL timeout_recover got valids=%0d expected 3 with 3/8", obs_q.size());
    end
  endtask

  task automatic test_reset_mid();
    fv = 0; pwm_in = 0;
    do_reset(); obs_q.delete();
    drive(0, 4);
    repeat (2) begin drive(1, 4); drive(0, 6); end
    drive(1, 2);
    do_reset(); obs_q.delete();
    n_cmp++;
    if ({valid, timeout, duty_out, period_out} !== '0) begin
      n_bad++; $display("FAIL midreset_outputs got v=%b to=%b duty=%0d per=%0d expected all 0",
                        valid, timeout, duty_out, period_out);
    end
    drive(1, 1); drive(0, 6);
    repeat (3) begin drive(1, 4); drive(0, 6); end
    n_cmp++;
    if (obs_q.size() < 2 || obs_q[obs_q.size()-1].duty != 4 || obs_q[obs_q.size()-1].per != 10) begin
      n_bad++; $display("FAIL midreset_recover got valids=%0d expected last 4/10", obs_q.size());
    end
  endtask

  task automatic test_glitch();
    fv = 3; pwm_in = 0;
    do_reset(); obs_q.delete();
    drive(0, 4);
    repeat (3) begin drive(1, 1); drive(0, 19); end
    n_cmp++;
    if (obs_q.size() != 2 || obs_q[1].duty != 0 || obs_q[1].per != 5) begin
      n_bad++; $display("FAIL glitch_pulse got valids=%0d expected 2 with 0/5", obs_q.size());
    end
    fv = 0;
    do_reset(); obs_q.delete();
    drive(0, 4);
    repeat (3) begin drive(1, 3); drive(0, 5); end
    repeat (2) begin drive(1, 6); drive(0, 2); end
    drive(1, 2); drive(0, 4);
    n_cmp++;
    if (obs_q.size() != 5) begin
      n_bad++; $display("FAIL duty_change_count got %0d expected 5", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[2].duty != 3 || obs_q[2].per != 8 || obs_q[3].duty != 6 || obs_q[3].per != 8) begin
        n_bad++; $display("FAIL duty_change got %0d/%0d then %0d/%0d expected 3/8 then 6/8",
                          obs_q[2].duty, obs_q[2].per, obs_q[3].duty, obs_q[3].per);
      end
    end
  endtask

  task automatic test_loopback();
    fv = 1; pwm_in = 0;
    do_reset(); obs_q.delete();
    drive(0, 4);
    // Generator with 2^(R+1)-unit period and 128-unit duty, each unit fv+1 clocks.
    repeat (3) begin drive(1, 128 * 2); drive(0, 384 * 2); end
    drive(1, 4); drive(0, 4);
    n_cmp++;
    if (obs_q.size() != 3) begin
      n_bad++; $display("FAIL loopback_count got %0d expected 3", obs_q.size());
    end
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i].duty != 128 || obs_q[i].per != 512) begin
        n_bad++; $display("FAIL loopback_value[%0d] got %0d/%0d expected 128/512", i, obs_q[i].duty, obs_q[i].per);
      end
    end
  endtask

  task automatic test_random();
    int hs[6];
    int ls[6];
    int u;
    for (int r = 0; r < 3; r++) begin
      fv = TB'($urandom_range(0, 3));
      u  = int'(fv) + 1;
      pwm_in = 0;
      do_reset(); obs_q.delete();
      drive(0, 4);
      for (int k = 0; k < 6; k++) begin
        hs[k] = $urandom_range(1, 40);
        ls[k] = $urandom_range(1, 40);
        drive(1, hs[k]); drive(0, ls[k]);
      end
      drive(1, 3); drive(0, 4);
      n_cmp++;
      if (obs_q.size() != 6) begin
        n_bad++; $display("FAIL random_count round=%0d got %0d expected 6", r, obs_q.size());
      end else begin
        for (int k = 0; k < 6; k++) begin
          n_cmp++;
          if (obs_q[k].duty != hs[k] / u || obs_q[k].per != (hs[k] + ls[k]) / u
              || obs_q[k].duty > obs_q[k].per) begin
            n_bad++; $display("FAIL random_value round=%0d k=%0d got %0d/%0d expected %0d/%0d",
                              r, k, obs_q[k].duty, obs_q[k].per, hs[k] / u, (hs[k] + ls[k]) / u);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; pwm_in = 1'b0; fv = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_scaled();
    test_timeout();
    test_reset_mid();
    test_glitch();
    test_loopback();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
